// File: rtl/alu_cmd_queue.sv
// In-order command buffer and registered issue stage feeding the ALU.
// Commands are queued in a circular buffer and issued one per cycle unless hold stalls the output.
module alu_cmd_queue #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_opcode,
  input  logic [DATA_W-1:0]        in_A,
  input  logic [DATA_W-1:0]        in_B,
  input  logic                     hold,
  output logic                     out_valid,
  output logic [OP_W-1:0]          Opcode,
  output logic [DATA_W-1:0]        A,
  output logic [DATA_W-1:0]        B,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         issue_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CMD_W = OP_W + 2 * DATA_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             out_valid_q;
  logic [OP_W-1:0]  opcode_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [CNT_W-1:0] issue_cnt_q;

  logic push, adv, pop;

  // in_ready ignores a same-cycle pop so it depends on registered state only
  assign in_ready = !reset && (count_q < FULL_CNT);
  assign push     = in_valid && in_ready && !flush;
  assign adv      = !out_valid_q || !hold;
  assign pop      = adv && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_opcode, in_A, in_B};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (adv) begin
        if (pop) begin
          {opcode_q, a_q, b_q} <= mem[rd_ptr_q];
          out_valid_q          <= 1'b1;
          rd_ptr_q             <= rd_ptr_q + 1'b1;
          issue_cnt_q          <= issue_cnt_q + 1'b1;
        end else begin
          // idle output stage presents a zeroed command
          out_valid_q <= 1'b0;
          opcode_q    <= '0;
          a_q         <= '0;
          b_q         <= '0;
        end
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign Opcode    = opcode_q;
  assign A         = a_q;
  assign B         = b_q;
  assign count     = count_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Randomized self-checking bench for alu_cmd_queue against a queue-based reference model.
module tb_alu_cmd_queue;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int CMD_W  = OP_W + 2 * DATA_W;
  localparam int OW     = 1 + CMD_W + CW + CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, flush, in_valid, hold, in_ready, out_valid;
  logic [OP_W-1:0]   in_opcode, Opcode;
  logic [DATA_W-1:0] in_A, in_B, A, B;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  issue_cnt;

  alu_cmd_queue #(
    .DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_A(in_A), .in_B(in_B), .hold(hold), .out_valid(out_valid),
    .Opcode(Opcode), .A(A), .B(B), .count(count), .issue_cnt(issue_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending commands in a queue plus the visible issued command
  logic [CMD_W-1:0] mq[$];
  logic             m_ov = 1'b0;
  logic [CMD_W-1:0] m_cmd = '0;
  logic [CNT_W-1:0] m_issue = '0;
  logic             rdy_obs, rdy_exp;
  logic [CMD_W-1:0] pend;

  wire [OW-1:0] dut_vec = {out_valid, Opcode, A, B, count, issue_cnt};

  function automatic logic [OW-1:0] exp_vec();
    return {m_ov, m_cmd, CW'(mq.size()), m_issue};
  endfunction

  // Drive one cycle of inputs, sample in_ready before the edge, update the model at the edge.
  task automatic cycle(input logic r, input logic f, input logic v, input logic h,
                       input logic [CMD_W-1:0] cmd);
    bit acc;
    reset = r; flush = f; in_valid = v; hold = h;
    {in_opcode, in_A, in_B} = cmd;
    #3;
    rdy_obs = in_ready;
    rdy_exp = !r && (mq.size() < DEPTH);
    @(posedge clk);
    if (r || f) begin
      mq.delete();
      m_ov = 1'b0; m_cmd = '0; m_issue = '0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      if (!m_ov || !h) begin
        if (mq.size() > 0) begin
          m_cmd = mq.pop_front(); m_ov = 1'b1; m_issue = m_issue + 1'b1;
        end else begin
          m_ov = 1'b0; m_cmd = '0;
        end
      end
      if (acc) mq.push_back(cmd);
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 1, 0, '1);
    n_checks++;
    if (rdy_obs !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 0", rdy_obs);
    end
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL reset_state got %h want 0", dut_vec);
    end
    cycle(0, 0, 0, 0, '0);
    n_checks++;
    if (rdy_obs !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready got %b want 1", rdy_obs);
    end
  endtask

  task automatic test_single();
    cycle(0, 0, 1, 0, {3'd1, 4'd3, 4'd5});
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_no_bypass got %b want 0", out_valid);
    end
    cycle(0, 0, 0, 0, '0);
    n_checks++;
    if (dut_vec !== {1'b1, 3'd1, 4'd3, 4'd5, 4'd0, 16'd1}) begin
      n_fail++; $display("FAIL single_issue got %h want %h", dut_vec,
                         {1'b1, 3'd1, 4'd3, 4'd5, 4'd0, 16'd1});
    end
    cycle(0, 0, 0, 0, '0);
    n_checks++;
    if (dut_vec !== {1'b0, 11'd0, 4'd0, 16'd1}) begin
      n_fail++; $display("FAIL single_idle got %h want %h", dut_vec, {1'b0, 11'd0, 4'd0, 16'd1});
    end
  endtask

  task automatic test_hold_fill();
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      pend = CMD_W'($urandom);
      cycle(0, 0, 1, 1, pend);
      n_checks++;
      if (rdy_obs !== rdy_exp || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL hold_fill[%0d] got rdy=%b %h want rdy=%b %h", i, rdy_obs,
                           dut_vec, rdy_exp, exp_vec());
      end
    end
    // tenth attempt must have been refused: nine accepted, first on the outputs
    n_checks++;
    if ({rdy_obs, out_valid, count} !== {1'b0, 1'b1, 4'd8}) begin
      n_fail++; $display("FAIL hold_full got rdy=%b ov=%b cnt=%0d want rdy=0 ov=1 cnt=8",
                         rdy_obs, out_valid, count);
    end
  endtask

  task automatic test_full_pop();
    cycle(0, 0, 1, 0, pend);
    n_checks++;
    if ({rdy_obs, count} !== {1'b0, 4'd7}) begin
      n_fail++; $display("FAIL full_pop_edge got rdy=%b cnt=%0d want rdy=0 cnt=7", rdy_obs, count);
    end
    cycle(0, 0, 1, 0, pend);
    n_checks++;
    if (rdy_obs !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_ready got %b want 1", rdy_obs);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 0, '0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL drain[%0d] got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (issue_cnt !== 16'd10) begin
      n_fail++; $display("FAIL drain_issue_cnt got %0d want 10", issue_cnt);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 22; i++) begin
      cycle(0, 0, i < 20, 0, CMD_W'($urandom));
      n_checks++;
      if (dut_vec !== exp_vec() || count > 1) begin
        n_fail++; $display("FAIL stream[%0d] got %h want %h (count<=1)", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, CMD_W'($urandom));
    n_checks++;
    if ({out_valid, count} !== {1'b1, 4'd5}) begin
      n_fail++; $display("FAIL flush_setup got ov=%b cnt=%0d want ov=1 cnt=5", out_valid, count);
    end
    cycle(0, 1, 1, 1, CMD_W'($urandom));
    n_checks++;
    if (rdy_obs !== 1'b1 || dut_vec !== '0) begin
      n_fail++; $display("FAIL flush_clear got rdy=%b %h want rdy=1 0", rdy_obs, dut_vec);
    end
    cycle(0, 0, 0, 0, '0);
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL flush_push_dropped got %h want 0", dut_vec);
    end
  endtask

  task automatic test_random_reset();
    int accepted = 0;
    logic r, f, v, h;
    pend = CMD_W'($urandom);
    for (int cyc = 0; cyc < 2000 && accepted < 50; cyc++) begin
      r = ($urandom % 16) == 0;
      f = ($urandom % 25) == 0;
      v = ($urandom % 4) != 0;
      h = $urandom % 2;
      cycle(r, f, v, h, pend);
      n_checks++;
      if (rdy_obs !== rdy_exp || dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d] got rdy=%b %h want rdy=%b %h", cyc, rdy_obs,
                           dut_vec, rdy_exp, exp_vec());
      end
      if (r) begin
        n_checks++;
        if (dut_vec !== '0) begin
          n_fail++; $display("FAIL random_reset[%0d] got %h want 0", cyc, dut_vec);
        end
      end
      if (v && rdy_exp) begin
        if (!f) accepted++;
        pend = CMD_W'($urandom);
      end
    end
    n_checks++;
    if (accepted < 50) begin
      n_fail++; $display("FAIL random_budget got %0d accepted want 50", accepted);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_fill();
    test_full_pop();
    test_stream();
    test_flush();
    test_random_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
